// File: rtl/uart_tx_scheduler_pkg.sv
// ============================================================================
//  Module      : uart_tx_scheduler_pkg
//  Description : Shared state encoding, idle byte and pointer helper for the
//                UART transmit scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_tx_scheduler_pkg;

    // Scheduler states; the encoding is fixed so status taps stay stable.
    localparam logic [1:0] c_st_idle     = 2'b00;
    localparam logic [1:0] c_st_wait_rdy = 2'b01;
    localparam logic [1:0] c_st_send     = 2'b11;
    localparam logic [1:0] c_st_gap      = 2'b10;

    // Value presented on the byte bus whenever no byte is in flight.
    localparam logic [7:0] c_tx_idle_byte = 8'hFF;

    // Next round-robin start position after serving source idx.
    function automatic logic [2:0] wrap_inc(input logic [2:0] idx, input int num);
        if (int'(idx) >= num - 1) begin
            return 3'd0;
        end
        return idx + 3'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// ============================================================================
//  Module      : uart_tx_scheduler_rr_arbiter
//  Description : Combinational round-robin pick: first set request at or
//                above ptr, otherwise the lowest set request (wrap-around).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_scheduler_rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         ptr,
    output logic [2:0]         grant,
    output logic               valid
);

    logic       w_hi_found;
    logic [2:0] w_hi_idx;
    logic [2:0] w_lo_idx;

    // Scan downward so the lowest qualifying index is the one left standing.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = 3'd0;
        w_lo_idx   = 3'd0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_lo_idx = 3'(i);
                if (3'(i) >= ptr) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = 3'(i);
                end
            end
        end
    end

    assign grant = w_hi_found ? w_hi_idx : w_lo_idx;
    assign valid = |req;

endmodule

`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
// ============================================================================
//  Module      : uart_tx_scheduler
//  Description : Shares one UART byte transmitter between NUM_REQ sources.
//                Round-robin grant, ready/start/done handshake, timeout drop
//                and enforced inter-byte gap. All outputs registered.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = 17
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    input  logic                 err_clr,
    input  logic                 tx_ready,
    input  logic                 tx_done,
    output logic                 tx_ctrl,
    output logic [7:0]           tx_byte,
    output logic [2:0]           grant_id,
    output logic                 busy,
    output logic                 blue,
    output logic                 timeout_err
);

    // GAP_CYCLES of 0 still spends one cycle in GAP, same as GAP_CYCLES of 1.
    localparam logic [CNT_W-1:0] c_gap_last     = (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       r_state;
    logic [2:0]       r_rr_ptr;
    logic [7:0]       r_hold;
    logic [CNT_W-1:0] r_cnt;

    logic [2:0]       w_grant;
    logic             w_valid;
    logic [7:0]       w_sel_byte;
    logic             w_expired;

    uart_tx_scheduler_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req   (req),
        .ptr   (r_rr_ptr),
        .grant (w_grant),
        .valid (w_valid)
    );

    // Pick the winning source's byte out of the packed request data bus.
    always_comb begin
        w_sel_byte = c_tx_idle_byte;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant == 3'(i)) begin
                w_sel_byte = req_data[8*i +: 8];
            end
        end
    end

    // >= rather than == so a byte entering SEND on the expiry cycle still
    // times out one cycle later if tx_done never comes.
    assign w_expired = (r_cnt >= c_timeout_last);

    // Scheduler state machine; every output is loaded here so all are flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_rr_ptr    <= 3'd0;
            r_hold      <= c_tx_idle_byte;
            r_cnt       <= '0;
            ack         <= '0;
            tx_ctrl     <= 1'b0;
            tx_byte     <= c_tx_idle_byte;
            grant_id    <= 3'd0;
            busy        <= 1'b0;
            blue        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            ack     <= '0;
            tx_ctrl <= 1'b0;
            // A timeout below overrides this clear in the same cycle.
            if (err_clr) begin
                timeout_err <= 1'b0;
            end
            case (r_state)
                c_st_idle: begin
                    if (w_valid) begin
                        r_hold   <= w_sel_byte;
                        tx_byte  <= w_sel_byte;
                        grant_id <= w_grant;
                        ack      <= NUM_REQ'(1) << w_grant;
                        r_cnt    <= '0;
                        busy     <= 1'b1;
                        r_state  <= c_st_wait_rdy;
                    end
                end
                c_st_wait_rdy: begin
                    if (tx_ready) begin
                        tx_ctrl <= 1'b1;
                        blue    <= 1'b1;
                        r_cnt   <= r_cnt + 1'b1;
                        r_state <= c_st_send;
                    end else if (w_expired) begin
                        timeout_err <= 1'b1;
                        tx_byte     <= c_tx_idle_byte;
                        r_rr_ptr    <= wrap_inc(grant_id, NUM_REQ);
                        r_cnt       <= '0;
                        r_state     <= c_st_gap;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_st_send: begin
                    if (tx_done || w_expired) begin
                        if (!tx_done) begin
                            timeout_err <= 1'b1;
                        end
                        blue     <= 1'b0;
                        tx_byte  <= c_tx_idle_byte;
                        r_rr_ptr <= wrap_inc(grant_id, NUM_REQ);
                        r_cnt    <= '0;
                        r_state  <= c_st_gap;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_st_gap: begin
                    if (r_cnt == c_gap_last) begin
                        busy    <= 1'b0;
                        r_state <= c_st_idle;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    blue    <= 1'b0;
                    tx_byte <= c_tx_idle_byte;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
// ============================================================================
//  Module      : tb_uart_tx_scheduler
//  Description : Directed bench for uart_tx_scheduler. Instance A uses a
//                4-cycle gap and 64-cycle timeout, instance B a zero gap and
//                20-cycle timeout; both share the stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_scheduler;

    localparam int GAP_A = 4;
    localparam int TO_A  = 64;
    localparam int GAP_B = 0;
    localparam int TO_B  = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [15:0] req_data;
    logic        err_clr;
    logic        tx_ready;
    logic        tx_done;

    logic [1:0]  a_ack,     b_ack;
    logic        a_tx_ctrl, b_tx_ctrl;
    logic [7:0]  a_tx_byte, b_tx_byte;
    logic [2:0]  a_grant,   b_grant;
    logic        a_busy,    b_busy;
    logic        a_blue,    b_blue;
    logic        a_err,     b_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx_scheduler #(
        .NUM_REQ(2), .GAP_CYCLES(GAP_A), .TIMEOUT_CYCLES(TO_A), .CNT_W(8)
    ) u_dut_a (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(a_ack),
        .err_clr(err_clr), .tx_ready(tx_ready), .tx_done(tx_done),
        .tx_ctrl(a_tx_ctrl), .tx_byte(a_tx_byte), .grant_id(a_grant),
        .busy(a_busy), .blue(a_blue), .timeout_err(a_err)
    );

    uart_tx_scheduler #(
        .NUM_REQ(2), .GAP_CYCLES(GAP_B), .TIMEOUT_CYCLES(TO_B), .CNT_W(8)
    ) u_dut_b (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(b_ack),
        .err_clr(err_clr), .tx_ready(tx_ready), .tx_done(tx_done),
        .tx_ctrl(b_tx_ctrl), .tx_byte(b_tx_byte), .grant_id(b_grant),
        .busy(b_busy), .blue(b_blue), .timeout_err(b_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = 2'b00; req_data = 16'h5A41; err_clr = 1'b0;
        tx_ready = 1'b0; tx_done = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        req = 2'b00; req_data = 16'h5A41; err_clr = 1'b0;
        tx_ready = 1'b0; tx_done = 1'b0;
        rst = 1'b1;
        #3;
        n_vec++;
        if ({a_tx_byte, a_tx_ctrl, a_ack, a_grant, a_busy, a_blue, a_err} !== {8'hFF, 1'b0, 2'b00, 3'd0, 3'b000}) begin
            n_err++;
            $display("FAIL reset_a: got %h, want %h", {a_tx_byte, a_tx_ctrl, a_ack, a_grant, a_busy, a_blue, a_err}, {8'hFF, 1'b0, 2'b00, 3'd0, 3'b000});
        end
        n_vec++;
        if ({b_tx_byte, b_busy, b_err} !== {8'hFF, 2'b00}) begin
            n_err++;
            $display("FAIL reset_b: got %h, want %h", {b_tx_byte, b_busy, b_err}, {8'hFF, 2'b00});
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        req = 2'b01; tx_ready = 1'b1;
        tick();
        n_vec++;
        if ({a_ack, a_grant, a_tx_byte, a_tx_ctrl} !== {2'b01, 3'd0, 8'h41, 1'b0}) begin
            n_err++;
            $display("FAIL single_ack: got %h, want %h", {a_ack, a_grant, a_tx_byte, a_tx_ctrl}, {2'b01, 3'd0, 8'h41, 1'b0});
        end
        req = 2'b00;
        tick();
        n_vec++;
        if ({a_tx_ctrl, a_blue, a_ack, a_tx_byte} !== {1'b1, 1'b1, 2'b00, 8'h41}) begin
            n_err++;
            $display("FAIL single_start: got %h, want %h", {a_tx_ctrl, a_blue, a_ack, a_tx_byte}, {1'b1, 1'b1, 2'b00, 8'h41});
        end
        tick();
        n_vec++;
        if ({a_tx_ctrl, a_blue} !== 2'b01) begin
            n_err++;
            $display("FAIL single_send: got %b, want %b", {a_tx_ctrl, a_blue}, 2'b01);
        end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        n_vec++;
        if ({a_blue, a_tx_byte, a_busy, b_busy, b_blue} !== {1'b0, 8'hFF, 1'b1, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL single_gap_entry: got %h, want %h", {a_blue, a_tx_byte, a_busy, b_busy, b_blue}, {1'b0, 8'hFF, 1'b1, 1'b1, 1'b0});
        end
        tick();
        n_vec++;
        if ({a_busy, b_busy} !== 2'b10) begin
            n_err++;
            $display("FAIL gap_zero_one_cycle: got %b, want %b", {a_busy, b_busy}, 2'b10);
        end
        tick(); tick();
        n_vec++;
        if (a_busy !== 1'b1) begin
            n_err++;
            $display("FAIL gap_last_cycle: got %b, want %b", a_busy, 1'b1);
        end
        tick();
        n_vec++;
        if ({a_busy, a_tx_byte} !== {1'b0, 8'hFF}) begin
            n_err++;
            $display("FAIL gap_exit: got %h, want %h", {a_busy, a_tx_byte}, {1'b0, 8'hFF});
        end
    endtask

    task automatic test_reset_during_send();
        int bad;
        do_reset();
        req = 2'b01; tx_ready = 1'b1;
        tick();
        req = 2'b00;
        tick();
        n_vec++;
        if (a_blue !== 1'b1) begin
            n_err++;
            $display("FAIL rst_pre_send: got %b, want %b", a_blue, 1'b1);
        end
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({a_tx_byte, a_tx_ctrl, a_ack, a_grant, a_busy, a_blue, a_err} !== {8'hFF, 1'b0, 2'b00, 3'd0, 3'b000}) begin
            n_err++;
            $display("FAIL rst_mid_send: got %h, want %h", {a_tx_byte, a_tx_ctrl, a_ack, a_grant, a_busy, a_blue, a_err}, {8'hFF, 1'b0, 2'b00, 3'd0, 3'b000});
        end
        tick();
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (a_tx_ctrl !== 1'b0 || a_busy !== 1'b0 || a_ack !== 2'b00) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL rst_no_resume: got %0d active cycles, want 0", bad);
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_fairness();
        logic [7:0] exp_byte [4];
        logic [2:0] exp_id   [4];
        int gap;
        bit found;
        exp_byte = '{8'h41, 8'h5A, 8'h41, 8'h5A};
        exp_id   = '{3'd0, 3'd1, 3'd0, 3'd1};
        do_reset();
        req = 2'b11; tx_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            gap = 0;
            found = 1'b0;
            for (int c = 0; c < 40 && !found; c++) begin
                tick();
                gap++;
                if (a_tx_ctrl === 1'b1) found = 1'b1;
            end
            n_vec++;
            if (!found) begin
                n_err++;
                $display("FAIL fair_start_%0d: got no tx_ctrl in 40 cycles, want one", n);
            end
            n_vec++;
            if ({a_tx_byte, a_grant} !== {exp_byte[n], exp_id[n]}) begin
                n_err++;
                $display("FAIL fair_order_%0d: got byte %h id %0d, want byte %h id %0d", n, a_tx_byte, a_grant, exp_byte[n], exp_id[n]);
            end
            if (n > 0) begin
                n_vec++;
                if (gap < GAP_A + 2) begin
                    n_err++;
                    $display("FAIL fair_gap_%0d: got %0d cycles, want >= %0d", n, gap, GAP_A + 2);
                end
            end
            tick();
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
        end
        req = 2'b00; tx_ready = 1'b0;
    endtask

    task automatic test_stall();
        int bad;
        do_reset();
        req = 2'b01; tx_ready = 1'b0;
        tick();
        n_vec++;
        if (a_ack !== 2'b01) begin
            n_err++;
            $display("FAIL stall_ack: got %b, want %b", a_ack, 2'b01);
        end
        req = 2'b00;
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (a_tx_ctrl !== 1'b0 || a_tx_byte !== 8'h41 || a_blue !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL stall_hold: got %0d bad cycles, want 0", bad);
        end
        tx_ready = 1'b1;
        tick();
        n_vec++;
        if ({a_tx_ctrl, a_tx_byte} !== {1'b1, 8'h41}) begin
            n_err++;
            $display("FAIL stall_release: got %h, want %h", {a_tx_ctrl, a_tx_byte}, {1'b1, 8'h41});
        end
        tick();
        n_vec++;
        if (a_tx_ctrl !== 1'b0) begin
            n_err++;
            $display("FAIL stall_pulse_width: got %b, want %b", a_tx_ctrl, 1'b0);
        end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0; tx_ready = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        req = 2'b11; tx_ready = 1'b1;
        tick();
        n_vec++;
        if (b_ack !== 2'b01) begin
            n_err++;
            $display("FAIL to_first_ack: got %b, want %b", b_ack, 2'b01);
        end
        repeat (TO_B - 1) tick();
        n_vec++;
        if ({b_err, b_blue} !== 2'b01) begin
            n_err++;
            $display("FAIL to_before_expiry: got %b, want %b", {b_err, b_blue}, 2'b01);
        end
        tick();
        n_vec++;
        if ({b_err, b_blue, b_tx_byte} !== {1'b1, 1'b0, 8'hFF}) begin
            n_err++;
            $display("FAIL to_expiry: got %h, want %h", {b_err, b_blue, b_tx_byte}, {1'b1, 1'b0, 8'hFF});
        end
        tick();
        tick();
        n_vec++;
        if ({b_ack, b_grant, b_tx_byte} !== {2'b10, 3'd1, 8'h5A}) begin
            n_err++;
            $display("FAIL to_next_served: got %h, want %h", {b_ack, b_grant, b_tx_byte}, {2'b10, 3'd1, 8'h5A});
        end
        err_clr = 1'b1;
        tick();
        n_vec++;
        if (b_err !== 1'b0) begin
            n_err++;
            $display("FAIL to_err_clr: got %b, want %b", b_err, 1'b0);
        end
        repeat (TO_B - 2) tick();
        tick();
        n_vec++;
        if (b_err !== 1'b1) begin
            n_err++;
            $display("FAIL to_set_beats_clr: got %b, want %b", b_err, 1'b1);
        end
        tick();
        n_vec++;
        if (b_err !== 1'b0) begin
            n_err++;
            $display("FAIL to_clr_after_set: got %b, want %b", b_err, 1'b0);
        end
        err_clr = 1'b0; req = 2'b00; tx_ready = 1'b0;
    endtask

    task automatic test_coincidence();
        do_reset();
        req = 2'b01; tx_ready = 1'b1;
        tick();
        req = 2'b00;
        repeat (TO_B - 1) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        n_vec++;
        if ({b_err, b_busy, b_blue} !== 3'b010) begin
            n_err++;
            $display("FAIL coincide_done_wins: got %b, want %b", {b_err, b_busy, b_blue}, 3'b010);
        end
        tick();
        n_vec++;
        if ({b_err, b_busy} !== 2'b00) begin
            n_err++;
            $display("FAIL coincide_gap_exit: got %b, want %b", {b_err, b_busy}, 2'b00);
        end
        tx_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_reset_during_send();
        test_fairness();
        test_stall();
        test_timeout();
        test_coincidence();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
